// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the round engine: round count, FSM states,
// GF(2^8) helpers and the forward S-box table.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_REQ,
        ST_ROUND,
        ST_DONE
    } eng_state_e;

    // Byte b lives at bits [8*(255-b) +: 8], so entry 0x00 is the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column word is {row0, row1, row2, row3}, row 0 in the top byte.
    function automatic word_t mix_column(input word_t col);
        byte_t a0, a1, a2, a3;
        byte_t b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box lookup for one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // 8*(255-b) == {~b, 3'b000}
    assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption engine: one round per REQ/ROUND pass, round keys
// fetched from an external generator addressed by cur_round.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int unsigned KEY_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_ready,
    input  logic [127:0] orig_key,
    input  logic [127:0] cur_key,
    output logic [3:0]   cur_round,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [1:0] LAT_LOAD   = 2'(KEY_LAT - 1);

    eng_state_e   fsm_reg;
    state_t       state_reg;
    logic [3:0]   round_reg;
    logic [1:0]   lat_cnt_reg;
    logic         out_valid_reg;
    logic         busy_reg;
    logic [127:0] data_out_reg;

    state_t sub_bytes;
    state_t shift_rows;
    state_t mix_cols;

    genvar gi;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub
            aes_sbox u_sbox (
                .in_byte  (state_reg[127-8*gi -: 8]),
                .out_byte (sub_bytes[127-8*gi -: 8])
            );
        end

        // Output byte (row, col) takes input byte (row, col+row mod 4).
        for (gi = 0; gi < 16; gi++) begin : g_shift
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
            assign shift_rows[127-8*gi -: 8] = sub_bytes[127-8*SRC -: 8];
        end

        for (gi = 0; gi < 4; gi++) begin : g_mix
            assign mix_cols[127-32*gi -: 32] = mix_column(shift_rows[127-32*gi -: 32]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg       <= ST_IDLE;
            state_reg     <= '0;
            round_reg     <= '0;
            lat_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            data_out_reg  <= '0;
        end else begin
            case (fsm_reg)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= data_in;
                        busy_reg  <= 1'b1;
                        fsm_reg   <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    state_reg   <= state_reg ^ orig_key;
                    round_reg   <= 4'd1;
                    lat_cnt_reg <= LAT_LOAD;
                    fsm_reg     <= ST_REQ;
                end
                ST_REQ: begin
                    // cur_round has been stable for KEY_LAT edges when this expires
                    if (lat_cnt_reg == 2'd0) begin
                        fsm_reg <= ST_ROUND;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 2'd1;
                    end
                end
                ST_ROUND: begin
                    if (round_reg == LAST_ROUND) begin
                        data_out_reg  <= shift_rows ^ cur_key;
                        out_valid_reg <= 1'b1;
                        fsm_reg       <= ST_DONE;
                    end else begin
                        state_reg   <= mix_cols ^ cur_key;
                        round_reg   <= round_reg + 4'd1;
                        lat_cnt_reg <= LAT_LOAD;
                        fsm_reg     <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        round_reg     <= '0;
                        fsm_reg       <= ST_IDLE;
                    end
                end
                default: begin
                    fsm_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (fsm_reg == ST_IDLE) && key_ready;
    assign cur_round = round_reg;
    assign out_valid = out_valid_reg;
    assign data_out  = data_out_reg;
    assign busy      = busy_reg;

endmodule
